// File: rtl/bufz_bus_driver_ctrl_if.sv
// rtl/bufz_bus_driver_ctrl_if.sv - requestor/bank-side signal bundle for the bufz bus controller
// master drives requests and data; slave is the controller that drives the bufz banks.
interface bufz_bus_driver_ctrl_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   REQ;
  logic [NREQ*W-1:0] DATA;
  logic [NREQ-1:0]   GNT;
  logic [NREQ-1:0]   BUF_EN;
  logic [NREQ*W-1:0] BUF_I;
  logic              BUSY;
  logic [OW-1:0]     OWNER;

  modport master (
    output REQ, DATA,
    input  GNT, BUF_EN, BUF_I, BUSY, OWNER
  );

  modport slave (
    input  REQ, DATA,
    output GNT, BUF_EN, BUF_I, BUSY, OWNER
  );
endinterface

// File: rtl/bufz_bus_driver_ctrl.sv
// rtl/bufz_bus_driver_ctrl.sv - round-robin EN/data controller for banks of bufz_8 tristate drivers
// One bank drives at a time; a break-before-make dead time separates tenures.
module bufz_bus_driver_ctrl #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int DEAD    = 2,
  parameter int MAXHOLD = 16
) (
  input  logic CLK,
  input  logic RN,
  bufz_bus_driver_ctrl_if.slave bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAXHOLD + 2);
  localparam int DW = $clog2(DEAD + 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD);
  localparam logic [DW-1:0] DEAD_LEN = DW'(DEAD);
  localparam logic [OW:0]   NREQ_W   = (OW+1)'(NREQ);
  localparam logic [OW-1:0] LAST     = OW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t            state;
  logic [NREQ-1:0]   gnt;
  logic [NREQ*W-1:0] buf_i;
  logic [OW-1:0]     owner;
  logic [OW-1:0]     ptr;
  logic [HW-1:0]     hold;
  logic [DW-1:0]     dead;

  logic [OW:0]       idx;
  logic [OW-1:0]     win;
  logic              win_valid;
  logic [OW-1:0]     next_ptr;
  logic [NREQ*W-1:0] grant_data;
  logic              arb_fire;
  logic              preempt;

  // Rotating priority search starting at ptr.
  always_comb begin
    idx       = '0;
    win       = '0;
    win_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (OW+1)'(i);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!win_valid && bus.REQ[idx[OW-1:0]]) begin
        win       = idx[OW-1:0];
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    grant_data[win*W +: W] = bus.DATA[win*W +: W];
  end

  assign next_ptr = (win == LAST) ? '0 : win + 1'b1;
  assign arb_fire = win_valid && ((state == IDLE) || ((state == TURN) && (dead >= DEAD_LEN)));
  assign preempt  = (MAXHOLD != 0) && (hold == HOLD_MAX) && (|(bus.REQ & ~gnt));

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
      gnt   <= '0;
      buf_i <= '0;
      owner <= '0;
      ptr   <= '0;
      hold  <= '0;
      dead  <= '0;
    end else if (arb_fire) begin
      state <= DRIVE;
      gnt   <= NREQ'(1) << win;
      buf_i <= grant_data;
      owner <= win;
      ptr   <= next_ptr;
      hold  <= HW'(1);
      dead  <= '0;
    end else begin
      case (state)
        IDLE: state <= IDLE;
        DRIVE: begin
          if (!bus.REQ[owner] || preempt) begin
            state <= TURN;
            gnt   <= '0;
            buf_i <= '0;
            owner <= '0;
            hold  <= '0;
            dead  <= DW'(1);
          end else begin
            buf_i[owner*W +: W] <= bus.DATA[owner*W +: W];
            if (hold < HOLD_MAX) hold <= hold + 1'b1;
          end
        end
        TURN: begin
          // Dead time met with nobody asking: park in IDLE.
          if (dead >= DEAD_LEN) state <= IDLE;
          else                  dead  <= dead + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.GNT    = gnt;
  assign bus.BUF_EN = gnt;
  assign bus.BUF_I  = buf_i;
  assign bus.BUSY   = |gnt;
  assign bus.OWNER  = owner;
endmodule

// File: tb/tb_bufz_bus_driver_ctrl.sv
// tb/tb_bufz_bus_driver_ctrl.sv - directed self-checking bench for bufz_bus_driver_ctrl
module tb_bufz_bus_driver_ctrl;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int DEAD = 2;

  logic clk = 1'b0;
  logic rn;
  int   n_cmp = 0;
  int   n_bad = 0;

  bufz_bus_driver_ctrl_if #(.NREQ(NREQ), .W(W)) bus ();

  bufz_bus_driver_ctrl #(.NREQ(NREQ), .W(W), .DEAD(DEAD), .MAXHOLD(4)) u_dut (
    .CLK (clk),
    .RN  (rn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rn      = 1'b0;
    bus.REQ = '0;
    step(3);
    rn = 1'b1;
  endtask

  // Bus-safety monitor: at most one bank enabled, and >= DEAD idle cycles before any rise.
  logic prev_any = 1'b0;
  logic seen_fall = 1'b0;
  int   gap = 0;
  always @(negedge clk) begin
    expect_eq("onehot", 32'($countones(bus.BUF_EN) <= 1), 32'd1);
    if (|bus.BUF_EN) begin
      if (!prev_any && seen_fall) expect_eq("dead_gap", 32'(gap >= DEAD), 32'd1);
      gap = 0;
    end else begin
      if (prev_any) seen_fall = 1'b1;
      gap++;
    end
    prev_any = |bus.BUF_EN;
  end

  initial begin
    rn       = 1'b0;
    bus.REQ  = '0;
    bus.DATA = '0;
    step(2);
    expect_eq("rst_gnt",   32'(bus.GNT),    32'h0);
    expect_eq("rst_en",    32'(bus.BUF_EN), 32'h0);
    expect_eq("rst_bufi",  32'(bus.BUF_I),  32'h0);
    expect_eq("rst_busy",  32'(bus.BUSY),   32'h0);
    expect_eq("rst_owner", 32'(bus.OWNER),  32'h0);
    rn = 1'b1;

    // Single requestor, data follow, release
    bus.REQ  = 4'b0001;
    bus.DATA = 32'h0000_00A5;
    step(1);
    expect_eq("s_gnt",   32'(bus.GNT),    32'h1);
    expect_eq("s_en",    32'(bus.BUF_EN), 32'h1);
    expect_eq("s_bufi0", 32'(bus.BUF_I),  32'h0000_00A5);
    expect_eq("s_owner", 32'(bus.OWNER),  32'h0);
    expect_eq("s_busy",  32'(bus.BUSY),   32'h1);
    bus.DATA = 32'h0000_003C;
    step(1);
    expect_eq("s_bufi1", 32'(bus.BUF_I),  32'h0000_003C);
    step(3);
    expect_eq("s_hold",  32'(bus.BUF_EN), 32'h1);
    bus.REQ = 4'b0000;
    step(1);
    expect_eq("s_rel_en",   32'(bus.BUF_EN), 32'h0);
    expect_eq("s_rel_gnt",  32'(bus.GNT),    32'h0);
    expect_eq("s_rel_bufi", 32'(bus.BUF_I),  32'h0);
    expect_eq("s_rel_busy", 32'(bus.BUSY),   32'h0);
    step(3);

    // Full contention: order 0,1,2,3,0 with 4 EN cycles and 2 dead cycles each
    do_reset();
    bus.REQ  = 4'b1111;
    bus.DATA = 32'h4433_2211;
    step(1);
    for (int t = 0; t < 5; t++) begin
      int g;
      g = t % 4;
      expect_eq("rr_gnt",   32'(bus.GNT),   32'(1) << g);
      expect_eq("rr_owner", 32'(bus.OWNER), 32'(g));
      expect_eq("rr_bufi",  32'(bus.BUF_I), 32'(8'h11 * (g + 1)) << (8 * g));
      step(3);
      expect_eq("rr_en4",   32'(bus.BUF_EN), 32'(1) << g);
      step(1);
      expect_eq("rr_dead1", 32'(bus.BUF_EN), 32'h0);
      expect_eq("rr_own0",  32'(bus.OWNER),  32'h0);
      step(1);
      expect_eq("rr_dead2", 32'(bus.BUF_EN), 32'h0);
      step(1);
    end
    bus.REQ = 4'b0000;
    step(4);

    // Dead time: req0 releases while req2 is pending
    do_reset();
    bus.REQ  = 4'b0001;
    bus.DATA = 32'h00CC_00AA;
    step(1);
    expect_eq("d_gnt0", 32'(bus.BUF_EN), 32'h1);
    bus.REQ = 4'b0101;
    step(1);
    bus.REQ = 4'b0100;
    step(1);
    expect_eq("d_k0", 32'(bus.BUF_EN), 32'h0);
    step(1);
    expect_eq("d_k1", 32'(bus.BUF_EN), 32'h0);
    step(1);
    expect_eq("d_en2",   32'(bus.BUF_EN), 32'h4);
    expect_eq("d_own2",  32'(bus.OWNER),  32'h2);
    expect_eq("d_bufi2", 32'(bus.BUF_I),  32'h00CC_0000);
    bus.REQ = 4'b0000;
    step(4);

    // Lone requestor holds indefinitely, then is preempted once contended
    do_reset();
    bus.REQ  = 4'b0010;
    bus.DATA = 32'h7700_5A00;
    for (int i = 0; i < 20; i++) begin
      step(1);
      expect_eq("l_hold", 32'(bus.BUF_EN), 32'h2);
    end
    bus.REQ = 4'b1010;
    step(1);
    expect_eq("p_drop", 32'(bus.BUF_EN), 32'h0);
    step(1);
    expect_eq("p_dead", 32'(bus.BUF_EN), 32'h0);
    step(1);
    expect_eq("p_en3",   32'(bus.BUF_EN), 32'h8);
    expect_eq("p_own3",  32'(bus.OWNER),  32'h3);
    expect_eq("p_bufi3", 32'(bus.BUF_I),  32'h7700_0000);
    step(3);
    expect_eq("p_en3_4", 32'(bus.BUF_EN), 32'h8);
    step(1);
    expect_eq("p_drop3", 32'(bus.BUF_EN), 32'h0);
    step(2);
    expect_eq("p_regnt1", 32'(bus.BUF_EN), 32'h2);
    expect_eq("p_own1",   32'(bus.OWNER),  32'h1);

    // Asynchronous reset mid-tenure, then restart from ptr 0
    #1;
    rn = 1'b0;
    #1;
    expect_eq("ar_en",   32'(bus.BUF_EN), 32'h0);
    expect_eq("ar_gnt",  32'(bus.GNT),    32'h0);
    expect_eq("ar_bufi", 32'(bus.BUF_I),  32'h0);
    expect_eq("ar_busy", 32'(bus.BUSY),   32'h0);
    bus.REQ = 4'b1000;
    step(3);
    rn = 1'b1;
    step(1);
    expect_eq("ar_gnt3", 32'(bus.GNT),   32'h8);
    expect_eq("ar_own3", 32'(bus.OWNER), 32'h3);
    bus.REQ = 4'b1001;
    step(4);
    expect_eq("ar_pre", 32'(bus.BUF_EN), 32'h0);
    step(2);
    expect_eq("ar_gnt0", 32'(bus.GNT),   32'h1);
    expect_eq("ar_own0", 32'(bus.OWNER), 32'h0);
    bus.REQ = 4'b0000;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
